// File: rtl/spike_rate_encoder.sv
// Encodes one unsigned activation per fixed-length window into a single-bit spike train,
// using either rate coding (carry of a phase accumulator) or time-to-first-spike coding.
module spike_rate_encoder #(
    parameter int unsigned INT_WIDTH     = 4,
    parameter int unsigned WINDOW_LENGTH = 16,
    parameter int unsigned WINDOW_WIDTH  = 5,
    parameter int unsigned MODE          = 0,
    parameter int unsigned SILENT        = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INT_WIDTH-1:0]    in_value,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out,
    output logic                    busy,
    output logic                    window_done,
    output logic [WINDOW_WIDTH-1:0] spike_count
);

    localparam int unsigned INT_MAX = (1 << INT_WIDTH) - 1;

    if (WINDOW_LENGTH < 1) begin : g_bad_window_length
        $error("spike_rate_encoder: WINDOW_LENGTH must be at least 1");
    end
    if ((1 << WINDOW_WIDTH) <= WINDOW_LENGTH) begin : g_bad_window_width
        $error("spike_rate_encoder: WINDOW_WIDTH too narrow for WINDOW_LENGTH");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("spike_rate_encoder: MODE must be 0 or 1");
    end
    if (SILENT > 1) begin : g_bad_silent
        $error("spike_rate_encoder: SILENT must be 0 or 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [INT_WIDTH-1:0]    val_q, val_d;
    logic [INT_WIDTH-1:0]    acc_q, acc_d;
    logic [WINDOW_WIDTH-1:0] cnt_q, cnt_d;
    logic [WINDOW_WIDTH-1:0] spike_count_q, spike_count_d;
    logic                    out_q, out_d;
    logic                    busy_q, busy_d;
    logic                    done_pend_q, done_pend_d;
    logic                    window_done_q, window_done_d;

    logic [INT_WIDTH:0]      sum;
    logic                    spike;

    // Spike decision for the current window index held in cnt_q.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, val_q};
        spike = 1'b0;
        if (MODE == 0) begin
            spike = sum[INT_WIDTH];
        end else begin
            spike = (val_q != '0) && (32'(cnt_q) == (INT_MAX - 32'(val_q)));
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        val_d         = val_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        spike_count_d = spike_count_q;
        out_d         = 1'b0;
        busy_d        = busy_q;
        done_pend_d   = 1'b0;
        // window_done trails the last window cycle by one so it coincides with out returning low
        window_done_d = done_pend_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d         = in_value;
                    acc_d         = '0;
                    cnt_d         = '0;
                    spike_count_d = '0;
                    state_d       = RUN;
                    busy_d        = 1'b1;
                end
            end
            RUN: begin
                out_d = spike;
                if (MODE == 0) begin
                    acc_d = sum[INT_WIDTH-1:0];
                end
                if (spike_count_q != '1) begin
                    spike_count_d = spike_count_q + WINDOW_WIDTH'(spike);
                end
                cnt_d = cnt_q + WINDOW_WIDTH'(1);
                if (cnt_q == WINDOW_WIDTH'(WINDOW_LENGTH - 1)) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            val_q         <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            spike_count_q <= '0;
            out_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_pend_q   <= 1'b0;
            window_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            val_q         <= val_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            spike_count_q <= spike_count_d;
            out_q         <= out_d;
            busy_q        <= busy_d;
            done_pend_q   <= done_pend_d;
            window_done_q <= window_done_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out         = out_q;
    assign busy        = busy_q;
    assign window_done = window_done_q;
    assign spike_count = spike_count_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: four instances (rate/TTFS x window 16/8) share one stimulus
// stream and are checked every cycle against a window-timeline model.
module tb_spike_rate_encoder;

    localparam int NI = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_value = 4'd0;

    logic       in_ready_w [NI];
    logic       out_w      [NI];
    logic       busy_w     [NI];
    logic       done_w     [NI];
    logic [4:0] cnt_w      [NI];

    always #5 clk = ~clk;

    spike_rate_encoder #(.INT_WIDTH(4), .WINDOW_LENGTH(16), .WINDOW_WIDTH(5), .MODE(0), .SILENT(1)) u_r16 (
        .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .out(out_w[0]), .busy(busy_w[0]), .window_done(done_w[0]), .spike_count(cnt_w[0]));
    spike_rate_encoder #(.INT_WIDTH(4), .WINDOW_LENGTH(16), .WINDOW_WIDTH(5), .MODE(1), .SILENT(1)) u_t16 (
        .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .out(out_w[1]), .busy(busy_w[1]), .window_done(done_w[1]), .spike_count(cnt_w[1]));
    spike_rate_encoder #(.INT_WIDTH(4), .WINDOW_LENGTH(8), .WINDOW_WIDTH(5), .MODE(0), .SILENT(1)) u_r8 (
        .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .out(out_w[2]), .busy(busy_w[2]), .window_done(done_w[2]), .spike_count(cnt_w[2]));
    spike_rate_encoder #(.INT_WIDTH(4), .WINDOW_LENGTH(8), .WINDOW_WIDTH(5), .MODE(1), .SILENT(1)) u_t8 (
        .clk(clk), .rst(rst), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready_w[3]),
        .out(out_w[3]), .busy(busy_w[3]), .window_done(done_w[3]), .spike_count(cnt_w[3]));

    // Model: each instance remembers the edge of its current and previous accept.
    int n = 0;
    int cur_t  [NI] = '{-1, -1, -1, -1};
    int prev_t [NI] = '{-1, -1, -1, -1};
    int mval   [NI] = '{0, 0, 0, 0};
    bit chk_en = 1'b0;
    int total  = 0;
    int passed = 0;

    function automatic int wl_of(input int i);
        return (i >= 2) ? 8 : 16;
    endfunction

    function automatic int mode_of(input int i);
        return i % 2;
    endfunction

    // Spike at window index k for value v, straight from the coding rules.
    function automatic int spike_at(input int i, input int v, input int k);
        if (k < 0 || k >= wl_of(i)) return 0;
        if (mode_of(i) == 0) return ((k + 1) * v) / 16 - (k * v) / 16;
        return (v != 0 && k == 15 - v) ? 1 : 0;
    endfunction

    function automatic bit m_busy(input int i, input int m);
        return cur_t[i] >= 0 && m >= cur_t[i] && m <= cur_t[i] + wl_of(i) - 1;
    endfunction

    function automatic int exp_out(input int i, input int m);
        if (cur_t[i] < 0 || m < cur_t[i] + 1 || m > cur_t[i] + wl_of(i)) return 0;
        return spike_at(i, mval[i], m - cur_t[i] - 1);
    endfunction

    function automatic int exp_done(input int i, input int m);
        return ((cur_t[i] >= 0 && m == cur_t[i] + wl_of(i) + 1) ||
                (prev_t[i] >= 0 && m == prev_t[i] + wl_of(i) + 1)) ? 1 : 0;
    endfunction

    function automatic int exp_cnt(input int i, input int m);
        int last;
        int s;
        s = 0;
        if (cur_t[i] < 0 || m <= cur_t[i]) return 0;
        last = m - cur_t[i] - 1;
        if (last > wl_of(i) - 1) last = wl_of(i) - 1;
        for (int k = 0; k <= last; k++) s += spike_at(i, mval[i], k);
        return s;
    endfunction

    task automatic check(input string name, input int i, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s inst%0d edge %0d: got %0d, expected %0d", name, i, n, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                check("out",         i, int'(out_w[i]),      exp_out(i, n));
                check("busy",        i, int'(busy_w[i]),     int'(m_busy(i, n)));
                check("in_ready",    i, int'(in_ready_w[i]), int'(!m_busy(i, n)));
                check("window_done", i, int'(done_w[i]),     exp_done(i, n));
                check("spike_count", i, int'(cnt_w[i]),      exp_cnt(i, n));
            end
        end
    end

    // One clock: drive at negedge, then advance the model at the following posedge.
    task automatic step(input bit r, input bit v, input logic [3:0] val);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        in_value = val;
        @(posedge clk);
        n++;
        for (int i = 0; i < NI; i++) begin
            if (r) begin
                cur_t[i]  = -1;
                prev_t[i] = -1;
            end else if (v && !m_busy(i, n - 1)) begin
                prev_t[i] = cur_t[i];
                cur_t[i]  = n;
                mval[i]   = int'(val);
            end
        end
        if (r) chk_en = 1'b1;
    endtask

    logic [15:0] pat;

    initial begin
        pat = '0;
        step(1, 0, 0);
        step(1, 0, 0);

        // Value 8: rate-16 pattern and window counts across all variants.
        step(0, 1, 4'd8);
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 0);
            #2 pat[k] = out_w[0];
        end
        check("lit_pattern_r16_v8", 0, int'(pat), 32'h0000_AAAA);
        check("lit_cnt_r16_v8", 0, int'(cnt_w[0]), 8);
        check("lit_cnt_t16_v8", 1, int'(cnt_w[1]), 1);
        check("lit_cnt_r8_v8",  2, int'(cnt_w[2]), 4);
        check("lit_cnt_t8_v8",  3, int'(cnt_w[3]), 1);
        step(0, 0, 0);
        #2 check("lit_done_17_after_accept", 0, int'(done_w[0]), 1);

        // Back-to-back 15 then 0 with in_valid held.
        step(0, 1, 4'd15);
        repeat (17) step(0, 1, 4'd0);
        repeat (20) step(0, 0, 0);
        #2 check("lit_cnt_r16_zero_window", 0, int'(cnt_w[0]), 0);

        // TTFS values 15, 12, 0.
        step(0, 1, 4'd15);
        repeat (17) step(0, 0, 0);
        #2 check("lit_ttfs_v15", 1, int'(cnt_w[1]), 1);
        step(0, 1, 4'd12);
        repeat (17) step(0, 0, 0);
        #2 check("lit_ttfs_v12", 1, int'(cnt_w[1]), 1);
        step(0, 1, 4'd0);
        repeat (17) step(0, 0, 0);
        #2 check("lit_ttfs_v0", 1, int'(cnt_w[1]), 0);

        // Value 4 on the short window: TTFS index 11 lies outside it.
        step(0, 1, 4'd4);
        repeat (17) step(0, 0, 0);
        #2 begin
            check("lit_ttfs_w8_v4", 3, int'(cnt_w[3]), 0);
            check("lit_ttfs_w16_v4", 1, int'(cnt_w[1]), 1);
            check("lit_rate_w8_v4", 2, int'(cnt_w[2]), 2);
            check("lit_rate_w16_v4", 0, int'(cnt_w[0]), 4);
        end

        // in_valid held with a changing value.
        repeat (100) step(0, 1, 4'($urandom_range(0, 15)));
        repeat (20) step(0, 0, 0);

        // Reset at k = 6 of a value-8 window, then a fresh accept.
        step(0, 1, 4'd8);
        repeat (6) step(0, 0, 0);
        step(1, 0, 0);
        #2 begin
            check("lit_rst_out",      0, int'(out_w[0]),      0);
            check("lit_rst_busy",     0, int'(busy_w[0]),     0);
            check("lit_rst_cnt",      0, int'(cnt_w[0]),      0);
            check("lit_rst_in_ready", 0, int'(in_ready_w[0]), 1);
        end
        step(0, 1, 4'd8);
        repeat (17) step(0, 0, 0);
        #2 check("lit_cnt_after_rst", 0, int'(cnt_w[0]), 8);

        // Random traffic with occasional resets.
        repeat (2000) step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        repeat (20) step(0, 0, 0);

        @(negedge clk);
        #1 $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
